// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute controller for the 8-bit accumulator
// datapath; sequences memory operands, drives the shared alu, writes back A/B/C.
module alu_exec_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [7:0] operand,
  output logic       instr_ready,
  output logic [7:0] mem_addr,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [5:0] alu_opcode,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  input  logic [8:0] alu_out,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic       carry,
  output logic       done,
  output logic       bus_err
);

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDB   = 6'h02;
  localparam logic [5:0] OP_STA   = 6'h03;
  localparam logic [5:0] OP_STB   = 6'h04;
  localparam logic [5:0] OP_ADDA  = 6'h05;
  localparam logic [5:0] OP_ADDB  = 6'h06;
  localparam logic [5:0] OP_SUBA  = 6'h07;
  localparam logic [5:0] OP_SUBB  = 6'h08;
  localparam logic [5:0] OP_ANDA  = 6'h09;
  localparam logic [5:0] OP_ANDB  = 6'h0A;
  localparam logic [5:0] OP_ORA   = 6'h0B;
  localparam logic [5:0] OP_ORB   = 6'h0C;
  localparam logic [5:0] OP_LDCA  = 6'h0D;
  localparam logic [5:0] OP_LDCB  = 6'h0E;
  localparam logic [5:0] OP_ADDCA = 6'h0F;
  localparam logic [5:0] OP_ADDCB = 6'h10;
  localparam logic [5:0] OP_SUBCA = 6'h11;
  localparam logic [5:0] OP_SUBCB = 6'h12;
  localparam logic [5:0] OP_ANDCA = 6'h13;
  localparam logic [5:0] OP_ANDCB = 6'h14;
  localparam logic [5:0] OP_ORCA  = 6'h15;
  localparam logic [5:0] OP_ORCB  = 6'h16;
  localparam logic [5:0] OP_ASLA  = 6'h17;
  localparam logic [5:0] OP_ASRA  = 6'h18;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    EXEC
  } state_t;

  typedef struct packed {
    logic dst_a;
    logic dst_b;
    logic ldc;
    logic bypass;
    logic cflag;
    logic shift;
    logic st_b;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LDA: begin
        d.dst_a  = 1'b1;
        d.bypass = 1'b1;
      end
      OP_LDB: begin
        d.dst_b  = 1'b1;
        d.bypass = 1'b1;
      end
      OP_STB:  d.st_b = 1'b1;
      OP_ADDA, OP_SUBA, OP_ADDCA, OP_SUBCA: begin
        d.dst_a = 1'b1;
        d.cflag = 1'b1;
      end
      OP_ADDB, OP_SUBB, OP_ADDCB, OP_SUBCB: begin
        d.dst_b = 1'b1;
        d.cflag = 1'b1;
      end
      OP_ANDA, OP_ORA, OP_ANDCA, OP_ORCA: d.dst_a = 1'b1;
      OP_ANDB, OP_ORB, OP_ANDCB, OP_ORCB: d.dst_b = 1'b1;
      OP_LDCA: begin
        d.dst_a = 1'b1;
        d.ldc   = 1'b1;
      end
      OP_LDCB: begin
        d.dst_b = 1'b1;
        d.ldc   = 1'b1;
      end
      OP_ASLA, OP_ASRA: begin
        d.dst_a = 1'b1;
        d.cflag = 1'b1;
        d.shift = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // bit 0: needs a memory read, bit 1: memory write
  function automatic logic [1:0] route(input logic [5:0] op);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      OP_LDA, OP_LDB, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB,
      OP_ANDA, OP_ANDB, OP_ORA, OP_ORB: r = 2'b01;
      OP_STA, OP_STB: r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  state_t          state;
  logic [5:0]      op_q;
  logic [7:0]      opd_q;
  logic [7:0]      m_q;
  logic [CW-1:0]   wait_cnt;
  dec_t            ex;
  logic [1:0]      acc_rt;
  logic            timeout;

  assign ex      = decode(op_q);
  assign acc_rt  = route(opcode);
  assign timeout = (ACK_TIMEOUT != 0) &&
                   (wait_cnt == CW'(ACK_TIMEOUT - 1));

  assign alu_opcode = op_q;
  assign mem_addr   = opd_q;
  assign mem_wdata  = ex.st_b ? reg_b : reg_a;

  // operand steering for the shared alu
  always_comb begin
    alu_in1 = 8'h00;
    alu_in2 = 8'h00;
    unique case (1'b1)
      ex.shift: begin
        alu_in1 = reg_a;
        alu_in2 = 8'h00;
      end
      (ex.dst_a && !ex.shift): begin
        alu_in1 = ex.ldc ? m_q : reg_a;
        alu_in2 = m_q;
      end
      ex.dst_b: begin
        alu_in1 = m_q;
        alu_in2 = ex.ldc ? m_q : reg_b;
      end
      default: begin
        alu_in1 = 8'h00;
        alu_in2 = 8'h00;
      end
    endcase
  end

  // control FSM, memory strobes, writeback and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      opd_q       <= '0;
      m_q         <= '0;
      wait_cnt    <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      carry       <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      done        <= 1'b0;
      bus_err     <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= opcode;
            opd_q       <= operand;
            m_q         <= operand;
            wait_cnt    <= '0;
            instr_ready <= 1'b0;
            if (acc_rt[0]) begin
              state    <= MEM_RD;
              mem_read <= 1'b1;
            end else if (acc_rt[1]) begin
              state     <= MEM_WR;
              mem_write <= 1'b1;
            end else begin
              state <= EXEC;
              done  <= 1'b1;
            end
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            m_q      <= mem_rdata;
            mem_read <= 1'b0;
            state    <= EXEC;
            done     <= 1'b1;
          end else if (timeout) begin
            mem_read    <= 1'b0;
            bus_err     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_write   <= 1'b0;
            done        <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else if (timeout) begin
            mem_write   <= 1'b0;
            bus_err     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        EXEC: begin
          if (ex.dst_a)
            reg_a <= ex.bypass ? m_q : alu_out[7:0];
          if (ex.dst_b)
            reg_b <= ex.bypass ? m_q : alu_out[7:0];
          if (ex.cflag)
            carry <= alu_out[8];
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed bench with a reference alu, memory responder
// and an architectural A/B/carry model checked whenever the controller idles.
module tb_alu_exec_ctrl;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDB   = 6'h02;
  localparam logic [5:0] OP_STA   = 6'h03;
  localparam logic [5:0] OP_STB   = 6'h04;
  localparam logic [5:0] OP_ADDA  = 6'h05;
  localparam logic [5:0] OP_ADDB  = 6'h06;
  localparam logic [5:0] OP_SUBA  = 6'h07;
  localparam logic [5:0] OP_SUBB  = 6'h08;
  localparam logic [5:0] OP_ANDA  = 6'h09;
  localparam logic [5:0] OP_ANDB  = 6'h0A;
  localparam logic [5:0] OP_ORA   = 6'h0B;
  localparam logic [5:0] OP_ORB   = 6'h0C;
  localparam logic [5:0] OP_LDCA  = 6'h0D;
  localparam logic [5:0] OP_LDCB  = 6'h0E;
  localparam logic [5:0] OP_ADDCA = 6'h0F;
  localparam logic [5:0] OP_ADDCB = 6'h10;
  localparam logic [5:0] OP_SUBCA = 6'h11;
  localparam logic [5:0] OP_SUBCB = 6'h12;
  localparam logic [5:0] OP_ANDCA = 6'h13;
  localparam logic [5:0] OP_ANDCB = 6'h14;
  localparam logic [5:0] OP_ORCA  = 6'h15;
  localparam logic [5:0] OP_ORCB  = 6'h16;
  localparam logic [5:0] OP_ASLA  = 6'h17;
  localparam logic [5:0] OP_ASRA  = 6'h18;
  localparam logic [5:0] OP_JMP   = 6'h20;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [7:0] operand = '0;
  logic       instr_ready;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [5:0] alu_opcode;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [8:0] alu_out;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic       carry;
  logic       done;
  logic       bus_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] ea = '0;
  logic [7:0] eb = '0;
  logic       ec = 1'b0;
  bit         chk_en = 1'b0;

  int         resp_delay = 0;
  int         scnt = 0;
  int         last_len = 0;
  logic [7:0] a0, w0;
  logic       resp_ack = 1'b0;
  logic [7:0] resp_rdata = '0;
  logic       late_ack = 1'b0;

  assign mem_ack   = resp_ack | late_ack;
  assign mem_rdata = late_ack ? 8'hAA : resp_rdata;

  alu_exec_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .opcode(opcode), .operand(operand),
    .instr_ready(instr_ready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out),
    .reg_a(reg_a), .reg_b(reg_b), .carry(carry),
    .done(done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // reference alu: A ops are in1 op in2, B ops are B (in2) op M (in1)
  always_comb begin
    alu_out = 9'h000;
    case (alu_opcode)
      OP_ADDA, OP_ADDCA: alu_out = {1'b0, alu_in1} + {1'b0, alu_in2};
      OP_ADDB, OP_ADDCB: alu_out = {1'b0, alu_in2} + {1'b0, alu_in1};
      OP_SUBA, OP_SUBCA: alu_out = {1'b0, alu_in1} - {1'b0, alu_in2};
      OP_SUBB, OP_SUBCB: alu_out = {1'b0, alu_in2} - {1'b0, alu_in1};
      OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB:
        alu_out = {1'b0, alu_in1 & alu_in2};
      OP_ORA, OP_ORB, OP_ORCA, OP_ORCB:
        alu_out = {1'b0, alu_in1 | alu_in2};
      OP_LDCA: alu_out = {1'b0, alu_in1};
      OP_LDCB: alu_out = {1'b0, alu_in2};
      OP_ASLA: alu_out = {alu_in1, 1'b0};
      OP_ASRA: alu_out = {alu_in1[0], alu_in1[7], alu_in1[7:1]};
      default: alu_out = 9'h000;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] op);
    return op inside {OP_LDA, OP_LDB, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB,
                      OP_ANDA, OP_ANDB, OP_ORA, OP_ORB};
  endfunction

  // architectural effect of one retired instruction
  task automatic model_step(input logic [5:0] op, input logic [7:0] m);
    logic [8:0] r;
    case (op)
      OP_LDA, OP_LDCA: ea = m;
      OP_LDB, OP_LDCB: eb = m;
      OP_ADDA, OP_ADDCA: begin r = ea + m; ea = r[7:0]; ec = r[8]; end
      OP_ADDB, OP_ADDCB: begin r = eb + m; eb = r[7:0]; ec = r[8]; end
      OP_SUBA, OP_SUBCA: begin
        r = {1'b0, ea} - {1'b0, m}; ea = r[7:0]; ec = r[8];
      end
      OP_SUBB, OP_SUBCB: begin
        r = {1'b0, eb} - {1'b0, m}; eb = r[7:0]; ec = r[8];
      end
      OP_ANDA, OP_ANDCA: ea = ea & m;
      OP_ANDB, OP_ANDCB: eb = eb & m;
      OP_ORA, OP_ORCA:   ea = ea | m;
      OP_ORB, OP_ORCB:   eb = eb | m;
      OP_ASLA: begin ec = ea[7]; ea = ea << 1; end
      OP_ASRA: begin ec = ea[0]; ea = {ea[7], ea[7:1]}; end
      default: ;
    endcase
  endtask

  // issue one instruction; lat = cycles from accept to done/bus_err
  task automatic run(input logic [5:0] op, input logic [7:0] opd,
                     input int dly, output int lat, output logic berr);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_issue", int'(instr_ready), 1);
    resp_delay  = dly;
    instr_valid = 1'b1;
    opcode      = op;
    operand     = opd;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && !bus_err && lat < 60);
    berr = bus_err;
    if (lat >= 60) chk("retire_timeout", lat, 0);
    if (done) model_step(op, is_mem(op) ? mem[opd] : opd);
    @(negedge clk);
    chk("ready_after_retire", int'(instr_ready), 1);
  endtask

  // memory responder plus per-cycle compare against the model
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      scnt++;
      if (scnt == 1) begin
        a0 = mem_addr;
        w0 = mem_wdata;
      end else begin
        checks++;
        if (mem_addr !== a0 || (mem_write && mem_wdata !== w0)) begin
          errors++;
          $display("FAIL strobe_stable: addr %h/%h data %h/%h",
                   mem_addr, a0, mem_wdata, w0);
        end
      end
      if (resp_delay != 0 && scnt == resp_delay) begin
        resp_ack   = 1'b1;
        resp_rdata = mem[mem_addr];
        if (mem_write) mem[mem_addr] = mem_wdata;
      end else begin
        resp_ack = 1'b0;
      end
    end else begin
      resp_ack = 1'b0;
      if (scnt != 0) last_len = scnt;
      scnt = 0;
    end
    if (chk_en && !reset) begin
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rd_wr_exclusive: both strobes high");
      end
      if (instr_ready) begin
        checks++;
        if (reg_a !== ea || reg_b !== eb || carry !== ec) begin
          errors++;
          $display("FAIL model_regs: got A=%h B=%h C=%b expected A=%h B=%h C=%b",
                   reg_a, reg_b, carry, ea, eb, ec);
        end
      end
    end
  end

  initial begin
    int   lat;
    logic berr;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_a", int'(reg_a), 0);
    chk("rst_b", int'(reg_b), 0);
    chk("rst_c", int'(carry), 0);
    chk("rst_strobes", int'({mem_read, mem_write}), 0);
    chk("rst_pulses", int'({done, bus_err}), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run(OP_LDCA, 8'h7F, 0, lat, berr);
    chk("ldca_latency", lat, 1);
    run(OP_ADDCA, 8'h01, 0, lat, berr);
    chk("addca_latency", lat, 1);
    chk("t1_a", int'(reg_a), 8'h80);
    chk("t1_c", int'(carry), 0);

    run(OP_LDCA, 8'hFF, 0, lat, berr);
    run(OP_ADDCA, 8'h01, 0, lat, berr);
    chk("t2_a", int'(reg_a), 8'h00);
    chk("t2_c", int'(carry), 1);
    run(OP_ANDCA, 8'h0F, 0, lat, berr);
    chk("t2_and_a", int'(reg_a), 8'h00);
    chk("t2_and_c", int'(carry), 1);

    mem[8'h10] = 8'h05;
    run(OP_LDB, 8'h10, 3, lat, berr);
    chk("ldb_latency", lat, 4);
    chk("ldb_strobe_len", last_len, 3);
    chk("ldb_b", int'(reg_b), 8'h05);

    mem[8'h30] = 8'h06;
    run(OP_SUBB, 8'h30, 1, lat, berr);
    chk("subb_zero_wait_latency", lat, 2);
    chk("subb_b", int'(reg_b), 8'hFF);
    chk("subb_c", int'(carry), 1);
    run(OP_STB, 8'h20, 2, lat, berr);
    chk("stb_latency", lat, 3);
    chk("stb_strobe_len", last_len, 2);
    chk("stb_mem", int'(mem[8'h20]), 8'hFF);

    run(OP_LDCB, 8'h3C, 0, lat, berr);
    run(OP_ORCB, 8'hC0, 0, lat, berr);
    chk("orcb_b", int'(reg_b), 8'hFC);
    run(OP_LDCA, 8'h81, 0, lat, berr);
    run(OP_ASLA, 8'h00, 0, lat, berr);
    chk("asla_a", int'(reg_a), 8'h02);
    chk("asla_c", int'(carry), 1);
    run(OP_ASRA, 8'h00, 0, lat, berr);
    chk("asra_a", int'(reg_a), 8'h01);
    chk("asra_c", int'(carry), 0);
    mem[8'h44] = 8'h10;
    run(OP_ADDA, 8'h44, 2, lat, berr);
    run(OP_ORA, 8'h44, 1, lat, berr);
    run(OP_STA, 8'h21, 1, lat, berr);
    chk("sta_mem", int'(mem[8'h21]), int'(ea));
    run(OP_NOP, 8'h00, 0, lat, berr);
    chk("nop_latency", lat, 1);
    run(OP_JMP, 8'h12, 0, lat, berr);
    run(OP_BAD, 8'h34, 0, lat, berr);
    chk("ctrl_ops_keep_a", int'(reg_a), 8'h11);

    run(OP_LDA, 8'h40, 0, lat, berr);
    chk("timeout_latency", lat, 17);
    chk("timeout_buserr", int'(berr), 1);
    chk("timeout_strobe_len", last_len, 16);
    chk("timeout_a_kept", int'(reg_a), 8'h11);

    resp_delay  = 0;
    instr_valid = 1'b1;
    opcode      = OP_LDA;
    operand     = 8'h50;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_strobe_before", int'(mem_read), 1);
    reset = 1'b1;
    ea = '0; eb = '0; ec = 1'b0;
    @(negedge clk);
    chk("abort_strobe_dropped", int'(mem_read), 0);
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_regs", int'({reg_a, reg_b, carry}), 0);
    reset    = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_no_done", int'(done), 0);
    chk("late_ack_regs", int'({reg_a, reg_b, carry}), 0);
    chk("late_ack_ready", int'(instr_ready), 1);

    run(OP_LDCA, 8'h42, 0, lat, berr);
    chk("post_reset_a", int'(reg_a), 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
